// File: rtl/vtm_nnbit_jkdim_seq_if.sv
// Bus bundle for the sequential W^T * E engine: request, operand words,
// result word and status flags. The engine side uses the slave modport.
interface vtm_nnbit_jkdim_seq_if #(
  parameter int N = 8,
  parameter int J = 3,
  parameter int K = 3
);
  localparam int L = 2*(N-1)+J;

  logic             start;
  logic [J*K*N-1:0] g_input;
  logic [J*N-1:0]   e_input;
  logic [K*L-1:0]   o;
  logic             busy;
  logic             done;

  modport master (
    output start, g_input, e_input,
    input  o, busy, done
  );

  modport slave (
    input  start, g_input, e_input,
    output o, busy, done
  );
endinterface

// File: rtl/vtm_nnbit_jkdim_seq.sv
// Sequential transposed matrix-vector product o = W^T * E, one signed MAC
// per cycle over J*K cycles. Shares the forward mxv weight packing.
//
//  state | meaning
//  IDLE  | waiting for start; o holds the last completed result
//  RUN   | stepping j (inner) and k (outer), one MAC per cycle
//  DONE  | one-cycle done pulse, busy low, then back to IDLE
module vtm_nnbit_jkdim_seq #(
  parameter int N = 8,
  parameter int J = 3,
  parameter int K = 3
) (
  input logic               clk,
  input logic               rst,
  vtm_nnbit_jkdim_seq_if.slave bus
);
  localparam int L  = 2*(N-1)+J;
  localparam int JW = (J > 1) ? $clog2(J) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [J*K*N-1:0]   w_q;
  logic [J*N-1:0]     e_q;
  logic [K*L-1:0]     o_q;
  logic [JW-1:0]      j_q;
  logic [KW-1:0]      k_q;
  logic signed [L-1:0] acc_q;
  logic               busy_q;
  logic               done_q;

  logic signed [N-1:0]   w_el;
  logic signed [N-1:0]   e_el;
  logic signed [2*N-1:0] prod;
  logic signed [L-1:0]   acc_next;

  // Select the current W[j][k] and E[j] from the captured operands and form the next partial sum.
  always_comb begin
    w_el     = w_q[(int'(j_q)*K + int'(k_q))*N +: N];
    e_el     = e_q[int'(j_q)*N +: N];
    prod     = (2*N)'(w_el) * (2*N)'(e_el);
    acc_next = acc_q + L'(prod);
  end

  // Control FSM with operand capture, counters, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      w_q    <= '0;
      e_q    <= '0;
      o_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            w_q    <= bus.g_input;
            e_q    <= bus.e_input;
            j_q    <= '0;
            k_q    <= '0;
            acc_q  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (j_q == JW'(J-1)) begin
            o_q[int'(k_q)*L +: L] <= acc_next;
            acc_q <= '0;
            j_q   <= '0;
            if (k_q == KW'(K-1)) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end else begin
            j_q   <= j_q + JW'(1);
            acc_q <= acc_next;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o    = o_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_vtm_nnbit_jkdim_seq.sv
// Directed self-checking bench for vtm_nnbit_jkdim_seq.
module tb_vtm_nnbit_jkdim_seq;
  localparam int N = 8;
  localparam int J = 3;
  localparam int K = 3;
  localparam int L = 2*(N-1)+J;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   done_count = 0;
  int   wm [J][K];
  int   ev [J];

  always #5 clk = ~clk;

  vtm_nnbit_jkdim_seq_if #(.N(N), .J(J), .K(K)) bus ();
  vtm_nnbit_jkdim_seq #(.N(N), .J(J), .K(K)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // Count done pulses mid-cycle, away from the active edge.
  always @(negedge clk) if (bus.done === 1'b1) done_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inputs();
    for (int j = 0; j < J; j++) begin
      for (int k = 0; k < K; k++) bus.g_input[(j*K+k)*N +: N] = N'(wm[j][k]);
      bus.e_input[j*N +: N] = N'(ev[j]);
    end
  endtask

  task automatic load_case1();
    wm[0][0] = -1; wm[0][1] = 2; wm[0][2] = -3;
    wm[1][0] =  2; wm[1][1] = 3; wm[1][2] = -4;
    wm[2][0] = -4; wm[2][1] = 5; wm[2][2] =  7;
    ev[0] = 2; ev[1] = 3; ev[2] = -4;
  endtask

  task automatic fill_all(input int wv, input int evv);
    for (int j = 0; j < J; j++) begin
      for (int k = 0; k < K; k++) wm[j][k] = wv;
      ev[j] = evv;
    end
  endtask

  // Behavioural W^T * E for column k, wrapped to L bits.
  function automatic logic [L-1:0] model_o(input int k);
    int s = 0;
    for (int j = 0; j < J; j++) s += wm[j][k] * ev[j];
    return L'(s);
  endfunction

  task automatic wait_done(output int cyc, output bit timeout);
    cyc = 0;
    timeout = 1'b0;
    while (bus.done !== 1'b1) begin
      tick();
      cyc++;
      if (cyc > 40) begin
        timeout = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.g_input = '0;
    bus.e_input = '0;
    tick(); tick();
    rst = 1'b1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++;
    if (bus.o !== '0) begin errors++; $display("FAIL reset_o: got %h expected 0", bus.o); end
  endtask

  task automatic test_basic();
    int cyc;
    bit to;
    logic [L-1:0] exp [K];
    logic [K*L-1:0] held;
    exp[0] = L'(20); exp[1] = L'(-7); exp[2] = L'(-46);
    load_case1();
    drive_inputs();
    pulse_start();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    wait_done(cyc, to);
    checks++;
    if (to || cyc != J*K) begin errors++; $display("FAIL basic_latency: got %0d edges (timeout=%0d) expected %0d", cyc, to, J*K); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", bus.busy); end
    for (int k = 0; k < K; k++) begin
      checks++;
      if (bus.o[k*L +: L] !== exp[k]) begin
        errors++;
        $display("FAIL basic_o[%0d]: got %0d expected %0d", k, $signed(bus.o[k*L +: L]), $signed(exp[k]));
      end
    end
    held = bus.o;
    tick();
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", bus.done); end
    tick(); tick();
    checks++;
    if (bus.o !== held) begin errors++; $display("FAIL basic_o_stable: got %h expected %h", bus.o, held); end
  endtask

  task automatic test_extremes();
    int cyc;
    bit to;
    fill_all(-128, -128);
    drive_inputs();
    pulse_start();
    wait_done(cyc, to);
    for (int k = 0; k < K; k++) begin
      checks++;
      if (to || bus.o[k*L +: L] !== L'(49152)) begin
        errors++;
        $display("FAIL ext_neg_o[%0d]: got %0d expected 49152", k, $signed(bus.o[k*L +: L]));
      end
    end
    tick();
    fill_all(127, -128);
    drive_inputs();
    pulse_start();
    wait_done(cyc, to);
    for (int k = 0; k < K; k++) begin
      checks++;
      if (to || bus.o[k*L +: L] !== L'(-48768)) begin
        errors++;
        $display("FAIL ext_mix_o[%0d]: got %0d expected -48768", k, $signed(bus.o[k*L +: L]));
      end
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int cyc;
    bit to;
    int dc0;
    logic [L-1:0] exp [K];
    exp[0] = L'(20); exp[1] = L'(-7); exp[2] = L'(-46);
    dc0 = done_count;
    load_case1();
    drive_inputs();
    pulse_start();
    tick(); tick();
    fill_all(9, 11);
    drive_inputs();
    pulse_start();
    wait_done(cyc, to);
    for (int k = 0; k < K; k++) begin
      checks++;
      if (to || bus.o[k*L +: L] !== exp[k]) begin
        errors++;
        $display("FAIL ignore_o[%0d]: got %0d expected %0d", k, $signed(bus.o[k*L +: L]), $signed(exp[k]));
      end
    end
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (done_count - dc0 != 1) begin errors++; $display("FAIL ignore_done_pulses: got %0d expected 1", done_count - dc0); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_no_requeue: busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    bit to;
    int dc0;
    logic [L-1:0] exp [K];
    exp[0] = L'(20); exp[1] = L'(-7); exp[2] = L'(-46);
    load_case1();
    drive_inputs();
    pulse_start();
    for (int i = 0; i < 4; i++) tick();
    dc0 = done_count;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (bus.o !== '0) begin errors++; $display("FAIL midrst_o: got %h expected 0", bus.o); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (done_count != dc0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_count - dc0); end
    pulse_start();
    wait_done(cyc, to);
    for (int k = 0; k < K; k++) begin
      checks++;
      if (to || bus.o[k*L +: L] !== exp[k]) begin
        errors++;
        $display("FAIL midrst_fresh_o[%0d]: got %0d expected %0d", k, $signed(bus.o[k*L +: L]), $signed(exp[k]));
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    int gap;
    bit to;
    logic [L-1:0] exp1 [K];
    logic [L-1:0] exp2 [K];
    exp1[0] = L'(20); exp1[1] = L'(-7); exp1[2] = L'(-46);
    exp2[0] = L'(5);  exp2[1] = L'(-6); exp2[2] = L'(7);
    load_case1();
    drive_inputs();
    bus.start = 1'b1;
    tick();
    for (int j = 0; j < J; j++)
      for (int k = 0; k < K; k++) wm[j][k] = (j == k) ? 1 : 0;
    ev[0] = 5; ev[1] = -6; ev[2] = 7;
    drive_inputs();
    wait_done(cyc, to);
    checks++;
    if (to || cyc != J*K) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", cyc, J*K); end
    for (int k = 0; k < K; k++) begin
      checks++;
      if (bus.o[k*L +: L] !== exp1[k]) begin
        errors++;
        $display("FAIL b2b_first_o[%0d]: got %0d expected %0d", k, $signed(bus.o[k*L +: L]), $signed(exp1[k]));
      end
    end
    gap = 0;
    to = 1'b0;
    do begin
      tick();
      gap++;
      if (gap > 40) to = 1'b1;
    end while (bus.done !== 1'b1 && !to);
    bus.start = 1'b0;
    checks++;
    if (to || gap != J*K+2) begin errors++; $display("FAIL b2b_spacing: got %0d cycles expected %0d", gap, J*K+2); end
    for (int k = 0; k < K; k++) begin
      checks++;
      if (bus.o[k*L +: L] !== exp2[k]) begin
        errors++;
        $display("FAIL b2b_second_o[%0d]: got %0d expected %0d", k, $signed(bus.o[k*L +: L]), $signed(exp2[k]));
      end
    end
    tick(); tick(); tick();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_stop: busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_midrun_change();
    int cyc;
    bit to;
    logic [L-1:0] exp [K];
    for (int v = 0; v < 3; v++) begin
      for (int j = 0; j < J; j++) begin
        for (int k = 0; k < K; k++) wm[j][k] = ((v*53 + j*29 + k*17 + 5) % 256) - 128;
        ev[j] = ((v*71 + j*43 + 9) % 256) - 128;
      end
      for (int k = 0; k < K; k++) exp[k] = model_o(k);
      drive_inputs();
      pulse_start();
      tick(); tick(); tick();
      fill_all(v + 1, -(v + 3));
      drive_inputs();
      wait_done(cyc, to);
      for (int k = 0; k < K; k++) begin
        checks++;
        if (to || bus.o[k*L +: L] !== exp[k]) begin
          errors++;
          $display("FAIL midchg_v%0d_o[%0d]: got %0d expected %0d", v, k, $signed(bus.o[k*L +: L]), $signed(exp[k]));
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_busy_ignore();
    test_reset_midrun();
    test_back_to_back();
    test_midrun_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
